// File: rtl/vedic_pkg.sv
// Shared types and constants for the nibble-serial adder datapath.
package vedic_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} add_state_t;

  localparam int NIB_W = 4;

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// Request/response bundle for nibble_serial_add_ctrl; master = requesters and sink, slave = controller.
interface nibble_serial_add_ctrl_if #(
  parameter int WIDTH   = 16,
  parameter int NUM_REQ = 2
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_a;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]            req_cin;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [WIDTH-1:0]              rsp_sum;
  logic                          rsp_cout;
  logic [ID_W-1:0]               rsp_id;

  modport master (
    output req_valid, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
  );

endinterface

// File: rtl/nibble_serial_add_ctrl_nibble_add4.sv
// Combinational 4-bit ripple-carry slice built from full_adder cells.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module nibble_add4
  import vedic_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);
  logic [NIB_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NIB_W; i++) begin : g_fa
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .sum (sum[i]),
      .cout(c[i+1])
    );
  end

  assign cout = c[NIB_W];
endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Round-robin arbitrated WIDTH-bit adder that reuses one 4-bit slice, one nibble per cycle.
module nibble_serial_add_ctrl
  import vedic_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NUM_REQ = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  nibble_serial_add_ctrl_if.slave  bus,
  output logic                     busy
);
  localparam int NIB   = WIDTH / NIB_W;
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  add_state_t state, state_nxt;

  logic [ID_W-1:0]             rr_ptr, grant, rsp_id_q;
  logic                        any_req;
  logic [IDX_W-1:0]            nib_idx;
  logic                        carry;
  logic [NIB-1:0][NIB_W-1:0]   a_q, b_q, sum_q;
  logic                        rsp_valid_q, rsp_cout_q;
  logic [NIB_W-1:0]            s_sum;
  logic                        s_cout;
  logic                        last_nib;

  assign last_nib = (nib_idx == IDX_W'(NIB - 1));

  // First valid requester at or after rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    any_req = 1'b0;
    grant   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!any_req && bus.req_valid[(32'(rr_ptr) + k) % NUM_REQ]) begin
        any_req = 1'b1;
        grant   = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  // Gated by rst so nothing can be accepted while reset is held.
  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && any_req && !rst) bus.req_ready[grant] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req)       state_nxt = RUN;
      RUN:     if (last_nib)      state_nxt = DONE;
      DONE:    if (bus.rsp_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  nibble_add4 u_add (
    .a   (a_q[nib_idx]),
    .b   (b_q[nib_idx]),
    .cin (carry),
    .sum (s_sum),
    .cout(s_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      nib_idx     <= '0;
      carry       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_cout_q  <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            a_q      <= bus.req_a[grant];
            b_q      <= bus.req_b[grant];
            rsp_id_q <= grant;
            carry    <= bus.req_cin[grant];
            nib_idx  <= '0;
            rr_ptr   <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
          end
        end
        RUN: begin
          sum_q[nib_idx] <= s_sum;
          carry          <= s_cout;
          nib_idx        <= nib_idx + 1'b1;
          if (last_nib) begin
            rsp_valid_q <= 1'b1;
            rsp_cout_q  <= s_cout;
          end
        end
        DONE: begin
          if (bus.rsp_ready) rsp_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_id    = rsp_id_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench: constant vector table, corner sequences, and randomized ops against an arithmetic model.
module tb_nibble_serial_add_ctrl;
  localparam int W = 16;
  localparam int N = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  always #5 clk = ~clk;

  nibble_serial_add_ctrl_if #(.WIDTH(W), .NUM_REQ(N)) bus ();

  nibble_serial_add_ctrl #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Passive observers of the bus
  int cyc = 0, xfers = 0, ready_viol = 0;
  int gq[$], gt[$], rid_q[$];
  logic [16:0] rres_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < N; i++)
      if (bus.req_valid[i] && bus.req_ready[i]) begin
        gq.push_back(i);
        gt.push_back(cyc);
      end
    if (bus.rsp_valid && bus.rsp_ready) begin
      xfers <= xfers + 1;
      rid_q.push_back(int'(bus.rsp_id));
      rres_q.push_back({bus.rsp_cout, bus.rsp_sum});
    end
  end

  always @(negedge clk)
    if (bus.req_ready == 2'b11) ready_viol <= ready_viol + 1;

  // Reference model: unsigned addition and a round-robin pointer
  int model_ptr = 0;

  function automatic logic [16:0] model_add(input logic [15:0] a, input logic [15:0] b, input logic cin);
    return {1'b0, a} + {1'b0, b} + 17'(cin);
  endfunction

  function automatic int model_grant(input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(model_ptr + k) % N]) return (model_ptr + k) % N;
    return -1;
  endfunction

  task automatic run_op(input int id, input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input int stall, input bit mutate,
                        input logic [15:0] exp_sum, input logic exp_cout, input string tag);
    int w, lat, x0, g0;
    logic [15:0] s0;
    @(negedge clk);
    bus.req_a[id]     = a;
    bus.req_b[id]     = b;
    bus.req_cin[id]   = cin;
    bus.req_valid[id] = 1'b1;
    bus.rsp_ready     = (stall == 0);
    x0 = xfers;
    g0 = gq.size();
    #1;
    w = 0;
    while (!bus.req_ready[id] && w < 20) begin
      @(negedge clk); #1; w++;
    end
    if (w >= 20) begin
      timeout_fail($sformatf("%s accept", tag));
      bus.req_valid[id] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.req_valid[id] = 1'b0;
    if (mutate) begin
      bus.req_a[id]   = ~a;
      bus.req_b[id]   = a ^ b;
      bus.req_cin[id] = ~cin;
    end
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!bus.rsp_valid && lat < 20);
    check($sformatf("%s latency", tag), lat, 4);
    check($sformatf("%s sum", tag), bus.rsp_sum, exp_sum);
    check($sformatf("%s cout", tag), bus.rsp_cout, exp_cout);
    check($sformatf("%s id", tag), bus.rsp_id, id);
    if (gq.size() > g0) check($sformatf("%s grant", tag), gq[g0], id);
    else timeout_fail($sformatf("%s grant", tag));
    s0 = bus.rsp_sum;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check($sformatf("%s hold valid", tag), bus.rsp_valid, 1);
      check($sformatf("%s hold sum", tag), bus.rsp_sum, s0);
      check($sformatf("%s hold cout", tag), bus.rsp_cout, exp_cout);
      check($sformatf("%s hold busy", tag), busy, 1);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check($sformatf("%s valid drop", tag), bus.rsp_valid, 0);
    check($sformatf("%s idle", tag), busy, 0);
    check($sformatf("%s transfers", tag), xfers - x0, 1);
    model_ptr = (id + 1) % N;
  endtask

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, g0, r0, x0, v, e;
    logic [16:0] er;

    tbl[0] = '{0, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
    tbl[1] = '{1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    tbl[2] = '{0, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    tbl[3] = '{1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    tbl[4] = '{0, 16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0};
    tbl[5] = '{1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = '0;
    bus.rsp_ready = 1'b0;

    #1;
    check("reset rsp_valid", bus.rsp_valid, 0);
    check("reset rsp_sum", bus.rsp_sum, 0);
    check("reset rsp_cout", bus.rsp_cout, 0);
    check("reset rsp_id", bus.rsp_id, 0);
    check("reset req_ready", bus.req_ready, 0);
    check("reset busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;

    for (int i = 0; i < 6; i++)
      run_op(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].cin, 0, 1'b0,
             tbl[i].sum, tbl[i].cout, $sformatf("vec%0d", i));

    run_op(0, 16'h8000, 16'h8000, 1'b1, 3, 1'b0, 16'h0001, 1'b1, "stall");

    run_op(1, 16'h0F0F, 16'h1010, 1'b0, 0, 1'b1, 16'h1F1F, 1'b0, "capture");

    // Requester 1 pulses valid only while requester 0 is being served
    g0 = gq.size();
    fork
      run_op(0, 16'h00FF, 16'h0001, 1'b0, 0, 1'b0, 16'h0100, 1'b0, "drop");
      begin
        repeat (3) @(negedge clk);
        bus.req_a[1]     = 16'hDEAD;
        bus.req_valid[1] = 1'b1;
        @(negedge clk);
        bus.req_valid[1] = 1'b0;
      end
    join
    check("drop grant count", gq.size() - g0, 1);

    // Reset during the second RUN cycle
    @(negedge clk);
    bus.req_a[1] = 16'h1111; bus.req_b[1] = 16'h2222; bus.req_cin[1] = 1'b0;
    bus.req_valid[1] = 1'b1;
    bus.rsp_ready    = 1'b1;
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst busy", busy, 0);
    check("midrst rsp_valid", bus.rsp_valid, 0);
    check("midrst rsp_sum", bus.rsp_sum, 0);
    check("midrst rsp_cout", bus.rsp_cout, 0);
    check("midrst rsp_id", bus.rsp_id, 0);
    check("midrst req_ready", bus.req_ready, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
    x0 = xfers; v = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) v++;
    end
    check("midrst no rsp_valid", v, 0);
    check("midrst no transfer", xfers - x0, 0);

    // Both requesters valid continuously
    @(negedge clk);
    bus.req_a[0] = 16'h0101; bus.req_b[0] = 16'h0202; bus.req_cin[0] = 1'b0;
    bus.req_a[1] = 16'h7000; bus.req_b[1] = 16'h9000; bus.req_cin[1] = 1'b1;
    bus.rsp_ready = 1'b1;
    g0 = gq.size(); r0 = rid_q.size();
    bus.req_valid = 2'b11;
    w = 0;
    while (gq.size() - g0 < 4 && w < 80) begin
      @(negedge clk); w++;
    end
    bus.req_valid = '0;
    if (w >= 80) timeout_fail("rr grants");
    w = 0;
    while ((busy || rid_q.size() - r0 < 4) && w < 20) begin
      @(negedge clk); w++;
    end
    if (w >= 20) timeout_fail("rr drain");
    if (gq.size() - g0 >= 4 && rid_q.size() - r0 >= 4) begin
      for (int k = 0; k < 4; k++) begin
        e  = model_grant(2'b11);
        er = model_add(bus.req_a[e], bus.req_b[e], bus.req_cin[e]);
        check($sformatf("rr grant%0d", k), gq[g0 + k], e);
        check($sformatf("rr rsp_id%0d", k), rid_q[r0 + k], e);
        check($sformatf("rr result%0d", k), rres_q[r0 + k], er);
        if (k > 0) check($sformatf("rr gap%0d", k), gt[g0 + k] - gt[g0 + k - 1], 6);
        model_ptr = (e + 1) % N;
      end
    end
    check("rr ready onehot", ready_viol, 0);

    run_op(1, 16'hA5A5, 16'h5A5A, 1'b1, 0, 1'b0, 16'h0000, 1'b1, "after_rr");

    for (int i = 0; i < 20; i++) begin
      int          rid, rst_cyc;
      logic [15:0] ra, rb;
      logic        rc;
      rid     = $urandom_range(0, N - 1);
      ra      = 16'($urandom);
      rb      = 16'($urandom);
      rc      = 1'($urandom);
      rst_cyc = $urandom_range(0, 2);
      er      = model_add(ra, rb, rc);
      run_op(rid, ra, rb, rc, rst_cyc, 1'($urandom), er[15:0], er[16], $sformatf("rand%0d", i));
    end

    check("final ready onehot", ready_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Time-shares one 4-bit ripple-carry adder slice to add WIDTH-bit operands nibble-serially, least-significant nibble first, with the carry chained through a register.
- Arbitrates between NUM_REQ requesters, for example partial-product accumulation paths of the 16-bit Vedic multiplier, using round-robin.
- Returns the sum, carry-out and requester ID over a valid/ready response channel.
- Trades latency for area: one adder slice replaces a WIDTH-bit adder.

Parameters:
- WIDTH, 16, operand and sum width; must be a multiple of 4 and at least 4.
- NUM_REQ, 2, number of requesters; must be at least 2.
- NIB (derived, localparam), WIDTH/4, nibble passes per operation.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_a  in  NUM_REQ x WIDTH  operand A per requester.
- req_b  in  NUM_REQ x WIDTH  operand B per requester.
- req_cin  in  NUM_REQ  carry-in per requester.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accept.
- rsp_sum  out  WIDTH  A+B+cin, modulo 2^WIDTH.
- rsp_cout  out  1  carry out of bit WIDTH-1.
- rsp_id  out  $clog2(NUM_REQ)  index of the granted requester.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, nib_idx=0, carry=0, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, req_ready=0, busy=0.
- State IDLE:
  - grant = first i with req_valid[i]=1, searching from rr_ptr upward and wrapping at NUM_REQ.
  - req_ready[grant]=1 combinationally; req_ready is all-zero when no request is valid.
  - On the handshake (req_valid & req_ready): latch A, B and id; carry<=req_cin[grant]; nib_idx<=0; rr_ptr<=(grant+1) mod NUM_REQ; go to RUN.
- State RUN, one nibble per cycle:
  - Slice inputs: a=A[4*nib_idx+:4], b=B[4*nib_idx+:4], cin=carry.
  - Slice sum goes to rsp_sum[4*nib_idx+:4]; carry<=slice cout; nib_idx++.
  - When nib_idx==NIB-1: go to DONE and set rsp_valid<=1, rsp_cout<=slice cout.
- State DONE:
  - rsp_valid=1.
  - rsp_sum, rsp_cout and rsp_id stay stable until rsp_valid & rsp_ready.
  - On that handshake: rsp_valid<=0 and go to IDLE.
- Latency and throughput:
  - Accept edge E0; rsp_valid rises after edge E0+NIB, which is 4 cycles for WIDTH=16.
  - If rsp_ready=1 in the first DONE cycle, the next accept can occur 2 cycles after rsp_valid rises: one DONE cycle, then one IDLE cycle.
  - req_ready=0 in RUN and DONE, so there is no accept/response overlap.
- Boundary cases:
  - Full wrap (0xFFFF+0x0001) gives cout=1, sum=0.
  - cin=1 propagates through all nibbles.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - A requester that drops req_valid before being granted is skipped, with no side effects.
  - Operands are captured at accept; input changes after accept have no effect.
  - Reset in any state returns to IDLE immediately; any in-flight result is discarded and no response is issued.
- Arithmetic is unsigned; sum and cout together form a WIDTH+1-bit result.

Decomposition:
- Shared package vedic_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} add_state_t.
  - localparam NIB_W = 4.
- Sub-module nibble_add4: combinational 4-bit ripple-carry slice built from the existing full_adder cells, with Cin honoured on bit 0. It is instantiated once.
- The controller owns the FSM, round-robin arbiter, operand registers and result register.

Test Plan:
- Requester 0 sends 0x1234 + 0x4321, cin=1, rsp_ready held high:
  - expect rsp_valid exactly 4 cycles after accept;
  - rsp_sum=0x5556, rsp_cout=0, rsp_id=0.
- Requester 1 sends 0xFFFF + 0x0001, cin=0:
  - expect rsp_sum=0x0000, rsp_cout=1, rsp_id=1.
- Both requesters valid continuously, 4 operations:
  - grants in order 0,1,0,1;
  - req_ready is never high on both bits in the same cycle.
- Send 0x8000 + 0x8000, cin=1, with rsp_ready low for 3 cycles after rsp_valid rises:
  - outputs hold sum=0x0001, cout=1 throughout;
  - exactly one transfer occurs, and busy stays high until it completes.
- Assert rst for 1 cycle during the 2nd RUN cycle:
  - all outputs return to reset values asynchronously;
  - no response follows;
  - a fresh request afterwards completes correctly.
- Change req_a/req_b on the cycle after accept:
  - the result reflects the originally captured operands.
